td4_sequencer: RTL
==================

TD4_SEQUENCER -- requirements
Module: td4_sequencer

Interface
REQ-001 SHALL have parameter RESET_IP, default 4'h0, giving the instruction pointer value loaded at reset.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port run, input, 1; level high means free-running execution.
REQ-006 SHALL have port step, input, 1; a single-cycle pulse executes one instruction.
REQ-007 SHALL have port in_port, input, 4, the external input for IN A and IN B.
REQ-008 SHALL have port mem_req, output, 1, the program-ROM read request.
REQ-009 SHALL have port mem_addr, output, 4, the ROM address, equal to ip.
REQ-010 SHALL have port mem_ack, input, 1; mem_rdata is valid in the ack cycle.
REQ-011 SHALL have port mem_rdata, input, 8; bits [7:4] are the opcode and bits [3:0] are imm.
REQ-012 SHALL have ports reg_a, reg_b, out_port and ip, output, 4 each, the architectural registers.
REQ-013 SHALL have port cf, output, 1, the carry flag.
REQ-014 SHALL have port busy, output, 1; it is high in FETCH and EXEC.
REQ-015 SHALL have port retire, output, 1, a one-cycle pulse when an instruction commits.
REQ-016 SHALL have port halted, output, 1; see Configuration.

Function
REQ-017 SHALL implement an FSM with states IDLE, FETCH, EXEC and HALT.
REQ-018 In IDLE, when run=1 or step=1, SHALL go to FETCH on the next edge; step has no effect outside IDLE.
REQ-019 In FETCH:
- mem_req=1 and mem_addr=ip, held stable until mem_ack.
- On the mem_ack edge, latch mem_rdata into IR, drop mem_req and go to EXEC.
- Wait states are unbounded.
REQ-020 In EXEC, SHALL commit one instruction in one cycle and pulse retire.
- Next state is FETCH if run=1, otherwise IDLE.
- Deasserting run mid-FETCH completes the current instruction, then enters IDLE.
REQ-021 Opcode decode (all others execute as NOP):
- 0000 ADD A,imm; 0001 MOV A,B; 0010 IN A; 0011 MOV A,imm.
- 0100 MOV B,A; 0101 ADD B,imm; 0110 IN B; 0111 MOV B,imm.
- 1001 OUT B; 1011 OUT imm.
- 1110 JNC imm; 1111 JMP imm.
REQ-022 Every instruction, including NOP, SHALL set ip=ip+1 modulo 16 (15 wraps to 0), except taken jumps.
REQ-023 Every instruction SHALL clear cf, except ADD, which sets cf to the 5th bit of the 4-bit+4-bit sum.
REQ-024 ADD SHALL write the low 4 bits of the sum; e.g. A=9 plus imm 8 gives A=1, cf=1.
REQ-025 JNC SHALL use the cf value from before the instruction:
- cf=0: ip=imm.
- cf=1: ip=ip+1.
- cf is 0 afterwards in both cases.
REQ-026 in_port SHALL be sampled in the EXEC cycle.
REQ-027 Updated register values SHALL be visible the cycle after EXEC.
- Minimum step-to-retire latency: step at cycle t, mem_req at t+1, ack at t+1, EXEC/retire at t+2.
REQ-028 Registers SHALL change only in EXEC.

Reset
REQ-029 On rst, SHALL set state=IDLE, ip=RESET_IP, reg_a=0, reg_b=0, out_port=0, cf=0, IR=0, mem_req=0, busy=0, retire=0, halted=0.
REQ-030 Reset SHALL take priority over all inputs, including a mem_ack in the same cycle.
- Reset mid-FETCH drops mem_req on the next edge.
- The aborted instruction never commits.
REQ-031 After reset, the block SHALL remain in IDLE until run or step.

Configuration
REQ-032 Macro TD4_HALT_DETECT_EN, when defined, enables self-loop halt detection:
- Trigger: a committed JMP with imm==ip, or a taken JNC with imm==ip.
- Effect: the FSM enters HALT after EXEC and halted=1.
- HALT ignores run and step and is left only by rst.
REQ-033 Without TD4_HALT_DETECT_EN:
- halted SHALL be constant 0 and the HALT state absent.
- Self-loops re-fetch indefinitely while run=1.

Verification
REQ-034 Reset, then one step with ROM[0]=0x35 and ack the same cycle: mem_req at t+1, retire at t+2, reg_a=5, ip=1, cf=0, back in IDLE.
REQ-035 Carry: A=9; ADD A,8 (0x08) gives A=1, cf=1. Then JNC 0 (0xE0) gives ip=prior ip+1 and cf=0. A following JNC 0 gives ip=0.
REQ-036 Handshake: with run=1, delay mem_ack by 3 cycles. mem_req and mem_addr stay stable for all 4 cycles and exactly one retire follows.
REQ-037 Wrap: ip=15 executing NOP (0x80) gives ip=0. IN B with in_port=0xA, then OUT B (0x90), gives out_port=0xA.
REQ-038 Assert rst during FETCH with mem_ack high in the same cycle: no retire, ip=RESET_IP, all registers 0, mem_req=0 the next cycle.
REQ-039 With TD4_HALT_DETECT_EN, ROM[3]=0xF3 under run=1: halted=1 after its retire, no further mem_req, and step is ignored. Without the macro, mem_req recurs with addr 3.

Source files
------------

// File: rtl/td4_sequencer.sv
// td4_sequencer: TD4-style 4-bit CPU sequencer with a req/ack program-ROM port.
// FSM IDLE -> FETCH -> EXEC, one instruction committed per EXEC cycle.
// Optional build macro TD4_HALT_DETECT_EN adds a HALT state that is entered on a
// self-looping jump and is left only by rst.
module td4_sequencer #(
  parameter logic [3:0] RESET_IP = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  input  logic [3:0] in_port,
  output logic       mem_req,
  output logic [3:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic [3:0] reg_a,
  output logic [3:0] reg_b,
  output logic [3:0] out_port,
  output logic [3:0] ip,
  output logic       cf,
  output logic       busy,
  output logic       retire,
  output logic       halted
);

`ifdef TD4_HALT_DETECT_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_t;
`endif

  state_t      state_q, state_d;
  logic [3:0]  ip_q, ip_d;
  logic [3:0]  reg_a_q, reg_a_d;
  logic [3:0]  reg_b_q, reg_b_d;
  logic [3:0]  out_port_q, out_port_d;
  logic        cf_q, cf_d;
  logic [7:0]  ir_q, ir_d;
  logic        mem_req_q, mem_req_d;
  logic        busy_q, busy_d;
  logic        retire_q, retire_d;

  logic [3:0]  opcode;
  logic [3:0]  imm;
  logic [4:0]  sum_a;
  logic [4:0]  sum_b;

  assign opcode = ir_q[7:4];
  assign imm    = ir_q[3:0];
  // Carry is the fifth bit of the zero-extended 4+4 bit sum.
  assign sum_a  = {1'b0, reg_a_q} + {1'b0, imm};
  assign sum_b  = {1'b0, reg_b_q} + {1'b0, imm};

`ifdef TD4_HALT_DETECT_EN
  logic halted_q, halted_d;
  logic halt_hit;
  // A jump that is actually taken back onto its own address can never make progress.
  assign halt_hit = (state_q == S_EXEC) && (imm == ip_q) &&
                    ((opcode == 4'b1111) || ((opcode == 4'b1110) && !cf_q));
`endif

  // Next-state, instruction execute and registered-output decode.
  always_comb begin
    state_d    = state_q;
    ip_d       = ip_q;
    reg_a_d    = reg_a_q;
    reg_b_d    = reg_b_q;
    out_port_d = out_port_q;
    cf_d       = cf_q;
    ir_d       = ir_q;
    case (state_q)
      S_IDLE: begin
        if (run || step) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        ip_d = ip_q + 4'd1;
        cf_d = 1'b0;
        case (opcode)
          4'b0000: begin reg_a_d = sum_a[3:0]; cf_d = sum_a[4]; end
          4'b0001: reg_a_d = reg_b_q;
          4'b0010: reg_a_d = in_port;
          4'b0011: reg_a_d = imm;
          4'b0100: reg_b_d = reg_a_q;
          4'b0101: begin reg_b_d = sum_b[3:0]; cf_d = sum_b[4]; end
          4'b0110: reg_b_d = in_port;
          4'b0111: reg_b_d = imm;
          4'b1001: out_port_d = reg_b_q;
          4'b1011: out_port_d = imm;
          4'b1110: if (!cf_q) ip_d = imm;
          4'b1111: ip_d = imm;
          default: ;
        endcase
`ifdef TD4_HALT_DETECT_EN
        if (halt_hit)  state_d = S_HALT;
        else if (run)  state_d = S_FETCH;
        else           state_d = S_IDLE;
`else
        state_d = run ? S_FETCH : S_IDLE;
`endif
      end
      default: ;
    endcase
    // Outputs are registered from the upcoming state so they line up with it.
    mem_req_d = (state_d == S_FETCH);
    busy_d    = (state_d == S_FETCH) || (state_d == S_EXEC);
    retire_d  = (state_d == S_EXEC);
`ifdef TD4_HALT_DETECT_EN
    halted_d  = (state_d == S_HALT);
`endif
  end

  // State and architectural registers; reset wins over any same-cycle mem_ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ip_q       <= RESET_IP;
      reg_a_q    <= 4'h0;
      reg_b_q    <= 4'h0;
      out_port_q <= 4'h0;
      cf_q       <= 1'b0;
      ir_q       <= 8'h00;
      mem_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      retire_q   <= 1'b0;
`ifdef TD4_HALT_DETECT_EN
      halted_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ip_q       <= ip_d;
      reg_a_q    <= reg_a_d;
      reg_b_q    <= reg_b_d;
      out_port_q <= out_port_d;
      cf_q       <= cf_d;
      ir_q       <= ir_d;
      mem_req_q  <= mem_req_d;
      busy_q     <= busy_d;
      retire_q   <= retire_d;
`ifdef TD4_HALT_DETECT_EN
      halted_q   <= halted_d;
`endif
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = ip_q;
  assign reg_a    = reg_a_q;
  assign reg_b    = reg_b_q;
  assign out_port = out_port_q;
  assign ip       = ip_q;
  assign cf       = cf_q;
  assign busy     = busy_q;
  assign retire   = retire_q;
`ifdef TD4_HALT_DETECT_EN
  assign halted   = halted_q;
`else
  assign halted   = 1'b0;
`endif

endmodule
